// File: rtl/msdap_compute_engine_if.sv
// Bundles the memory ports, the start handshake and the result/status
// outputs of the compute engine. master = engine side, slave = host/memory side.
interface msdap_compute_engine_if #(
  parameter int NUM_CH     = 2,
  parameter int NUM_RJ     = 16,
  parameter int COEF_DEPTH = 512,
  parameter int DATA_DEPTH = 256,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RJ_W    = $clog2(NUM_RJ);
  localparam int COEF_AW = $clog2(COEF_DEPTH);
  localparam int DATA_AW = $clog2(DATA_DEPTH);

  logic               start_compute;
  logic [DATA_AW-1:0] newest_ptr;
  logic [RJ_W-1:0]    rj_addr;
  logic [15:0]        rj_data;
  logic [COEF_AW-1:0] coef_addr;
  logic [15:0]        coef_data;
  logic [DATA_AW-1:0] data_addr;
  logic [DATA_W-1:0]  data_data;
  logic [CH_W-1:0]    ch_sel;
  logic [ACC_W-1:0]   y_out;
  logic               y_valid;
  logic [CH_W-1:0]    y_ch;
  logic               busy;
  logic               done;
  logic               overrun;

  modport master (
    input  start_compute, newest_ptr, rj_data, coef_data, data_data,
    output rj_addr, coef_addr, data_addr, ch_sel,
           y_out, y_valid, y_ch, busy, done, overrun
  );

  modport slave (
    output start_compute, newest_ptr, rj_data, coef_data, data_data,
    input  rj_addr, coef_addr, data_addr, ch_sel,
           y_out, y_valid, y_ch, busy, done, overrun
  );
endinterface

// File: rtl/msdap_compute_engine.sv
// MSDAP filter compute engine: walks rj groups and coefficients per channel,
// accumulates signed, delayed samples into u, folds each group into acc with
// a halving shift, and reports one result per channel.
module msdap_compute_engine #(
  parameter int NUM_CH     = 2,
  parameter int NUM_RJ     = 16,
  parameter int COEF_DEPTH = 512,
  parameter int DATA_DEPTH = 256,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 40,
  parameter int FRAC_W     = 16
) (
  input  logic                  Sclk,
  input  logic                  Reset,
  msdap_compute_engine_if.master bus
);
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int RJ_W    = $clog2(NUM_RJ);
  localparam int J_W     = RJ_W + 1;
  localparam int COEF_AW = $clog2(COEF_DEPTH);
  localparam int DATA_AW = $clog2(DATA_DEPTH);
  localparam int FILL_W  = $clog2(DATA_DEPTH + 1);

  typedef enum logic [2:0] {
    IDLE, RJ_ADDR, RJ_LAT, C_ADDR, D_ADDR, ACC, SHIFT, OUT
  } state_t;

  state_t                    state;
  logic [CH_W-1:0]           ch;
  logic [J_W-1:0]            j;
  logic [COEF_AW-1:0]        coef_ptr;
  logic [DATA_AW-1:0]        newest_q;
  logic [15:0]               rcnt;
  logic                      sign_q;
  logic [7:0]                k_q;
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   u;
  logic [FILL_W-1:0]         filled;
  logic [ACC_W-1:0]          y_out_q;
  logic [CH_W-1:0]           y_ch_q;
  logic                      y_valid_q;
  logic                      done_q;
  logic                      busy_q;
  logic                      overrun_q;

  logic signed [ACC_W-1:0]   x_ext;
  logic signed [ACC_W-1:0]   acc_sum;
  logic                      term_live;
  logic                      unused_coef_bits;

  // Memory addresses follow the counters directly; the data address is formed
  // from the coefficient word arriving in D_ADDR, wrapping modulo DATA_DEPTH.
  assign bus.rj_addr   = j[RJ_W-1:0];
  assign bus.coef_addr = coef_ptr;
  assign bus.data_addr = newest_q - DATA_AW'(bus.coef_data[7:0]);
  assign bus.ch_sel    = ch;

  assign bus.y_out   = y_out_q;
  assign bus.y_ch    = y_ch_q;
  assign bus.y_valid = y_valid_q;
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

  assign unused_coef_bits = ^bus.coef_data[15:9];

  // Sample placed above FRAC_W zero LSBs and sign-extended to accumulator width.
  assign x_ext = {{(ACC_W - DATA_W - FRAC_W){bus.data_data[DATA_W-1]}},
                  bus.data_data, {FRAC_W{1'b0}}};
  assign acc_sum   = acc + u;
  // A delay reaching past the samples written so far contributes nothing.
  assign term_live = (32'(k_q) < 32'(filled));

  // Main sequencer: one state per cycle, all outputs registered here.
  always_ff @(posedge Sclk) begin
    if (Reset) begin
      state     <= IDLE;
      ch        <= '0;
      j         <= '0;
      coef_ptr  <= '0;
      newest_q  <= '0;
      rcnt      <= '0;
      sign_q    <= 1'b0;
      k_q       <= '0;
      acc       <= '0;
      u         <= '0;
      filled    <= '0;
      y_out_q   <= '0;
      y_ch_q    <= '0;
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      y_valid_q <= 1'b0;
      done_q    <= 1'b0;
      if (bus.start_compute && (state != IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (bus.start_compute) begin
            newest_q <= bus.newest_ptr;
            ch       <= '0;
            j        <= '0;
            coef_ptr <= '0;
            acc      <= '0;
            u        <= '0;
            if (filled < FILL_W'(DATA_DEPTH)) begin
              filled <= filled + 1'b1;
            end
            busy_q   <= 1'b1;
            state    <= RJ_ADDR;
          end
        end
        RJ_ADDR: state <= RJ_LAT;
        RJ_LAT: begin
          rcnt  <= bus.rj_data;
          state <= (bus.rj_data != 16'd0) ? C_ADDR : SHIFT;
        end
        C_ADDR: state <= D_ADDR;
        D_ADDR: begin
          sign_q   <= bus.coef_data[8];
          k_q      <= bus.coef_data[7:0];
          coef_ptr <= (coef_ptr == COEF_AW'(COEF_DEPTH - 1)) ? '0 : coef_ptr + 1'b1;
          state    <= ACC;
        end
        ACC: begin
          if (term_live) begin
            u <= sign_q ? (u - x_ext) : (u + x_ext);
          end
          rcnt  <= rcnt - 16'd1;
          state <= (rcnt != 16'd1) ? C_ADDR : SHIFT;
        end
        SHIFT: begin
          acc   <= acc_sum >>> 1;
          u     <= '0;
          j     <= j + 1'b1;
          state <= (j == J_W'(NUM_RJ - 1)) ? OUT : RJ_ADDR;
        end
        OUT: begin
          y_out_q   <= acc;
          y_ch_q    <= ch;
          y_valid_q <= 1'b1;
          if (ch < CH_W'(NUM_CH - 1)) begin
            ch       <= ch + 1'b1;
            j        <= '0;
            coef_ptr <= '0;
            acc      <= '0;
            u        <= '0;
            state    <= RJ_ADDR;
          end else begin
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_msdap_compute_engine.sv
// Directed bench for msdap_compute_engine with behavioural synchronous-read memories.
module tb_msdap_compute_engine;
  localparam int NUM_CH     = 2;
  localparam int NUM_RJ     = 16;
  localparam int COEF_DEPTH = 512;
  localparam int DATA_DEPTH = 256;
  localparam int DATA_W     = 16;
  localparam int ACC_W      = 40;
  localparam int FRAC_W     = 16;

  logic Sclk;
  logic Reset;

  int compare_count = 0;
  int fail_count    = 0;

  logic [15:0]       rj_mem   [NUM_CH][NUM_RJ];
  logic [15:0]       coef_mem [NUM_CH][COEF_DEPTH];
  logic [DATA_W-1:0] data_mem [NUM_CH][DATA_DEPTH];

  msdap_compute_engine_if #(
    .NUM_CH(NUM_CH), .NUM_RJ(NUM_RJ), .COEF_DEPTH(COEF_DEPTH),
    .DATA_DEPTH(DATA_DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W)
  ) bus ();

  msdap_compute_engine #(
    .NUM_CH(NUM_CH), .NUM_RJ(NUM_RJ), .COEF_DEPTH(COEF_DEPTH),
    .DATA_DEPTH(DATA_DEPTH), .DATA_W(DATA_W), .ACC_W(ACC_W), .FRAC_W(FRAC_W)
  ) dut (
    .Sclk (Sclk),
    .Reset(Reset),
    .bus  (bus)
  );

  initial Sclk = 1'b0;
  always #5 Sclk = ~Sclk;

  // Synchronous-read memories: data appears the cycle after the address.
  always @(posedge Sclk) begin
    bus.rj_data   <= rj_mem[bus.ch_sel][bus.rj_addr];
    bus.coef_data <= coef_mem[bus.ch_sel][bus.coef_addr];
    bus.data_data <= data_mem[bus.ch_sel][bus.data_addr];
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
    compare_count++;
    if (got !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    end
  endtask

  task automatic clearMems();
    for (int c = 0; c < NUM_CH; c++) begin
      for (int i = 0; i < NUM_RJ; i++) rj_mem[c][i] = 16'd0;
      for (int i = 0; i < COEF_DEPTH; i++) coef_mem[c][i] = 16'd0;
      for (int i = 0; i < DATA_DEPTH; i++) data_mem[c][i] = '0;
    end
  endtask

  task automatic fillChannel(input int c, input logic [15:0] rj, input logic [15:0] coef,
                             input logic [DATA_W-1:0] data);
    for (int i = 0; i < NUM_RJ; i++) rj_mem[c][i] = rj;
    for (int i = 0; i < COEF_DEPTH; i++) coef_mem[c][i] = coef;
    for (int i = 0; i < DATA_DEPTH; i++) data_mem[c][i] = data;
  endtask

  // Issue one start and follow the run to done, checking both channel results.
  task automatic applyStimulus(input string name, input logic [7:0] newest,
                               input int exp_cyc0, input logic [ACC_W-1:0] exp_y0,
                               input int exp_cyc1, input logic [ACC_W-1:0] exp_y1,
                               input int overrun_at, input int probe_cyc,
                               input logic [7:0] exp_daddr, input bit coef_still);
    int cyc;
    int n_valid;
    bit coef_moved;
    bit finished;
    bus.newest_ptr    = newest;
    bus.start_compute = 1'b1;
    @(posedge Sclk);
    #1;
    bus.start_compute = 1'b0;
    checkOutput({name, "_busy_after_start"}, 64'(bus.busy), 64'd1);
    cyc = 0;
    n_valid = 0;
    coef_moved = 1'b0;
    finished = 1'b0;
    while (!finished && cyc < 1000) begin
      @(posedge Sclk);
      #1;
      cyc++;
      bus.start_compute = (cyc == overrun_at);
      if (cyc == probe_cyc) checkOutput({name, "_data_addr"}, 64'(bus.data_addr), 64'(exp_daddr));
      if (bus.coef_addr != '0) coef_moved = 1'b1;
      if (bus.y_valid) begin
        if (n_valid == 0) begin
          checkOutput({name, "_y_ch0"}, 64'(bus.y_ch), 64'd0);
          checkOutput({name, "_cycles0"}, 64'(cyc), 64'(exp_cyc0));
          checkOutput({name, "_y_out0"}, 64'(bus.y_out), 64'(exp_y0));
          checkOutput({name, "_done_early"}, 64'(bus.done), 64'd0);
        end else if (n_valid == 1) begin
          checkOutput({name, "_y_ch1"}, 64'(bus.y_ch), 64'd1);
          checkOutput({name, "_cycles1"}, 64'(cyc), 64'(exp_cyc1));
          checkOutput({name, "_y_out1"}, 64'(bus.y_out), 64'(exp_y1));
          checkOutput({name, "_done_with_last"}, 64'(bus.done), 64'd1);
        end
        n_valid++;
      end
      if (bus.done) finished = 1'b1;
    end
    bus.start_compute = 1'b0;
    checkOutput({name, "_finished"}, 64'(finished), 64'd1);
    checkOutput({name, "_valid_count"}, 64'(n_valid), 64'd2);
    checkOutput({name, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    if (coef_still) checkOutput({name, "_coef_addr_still"}, 64'(coef_moved), 64'd0);
  endtask

  initial begin
    int stray;
    Reset = 1'b1;
    bus.start_compute = 1'b0;
    bus.newest_ptr = '0;
    clearMems();
    repeat (3) @(posedge Sclk);
    #1;
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_y_valid", 64'(bus.y_valid), 64'd0);
    checkOutput("rst_done", 64'(bus.done), 64'd0);
    checkOutput("rst_overrun", 64'(bus.overrun), 64'd0);
    checkOutput("rst_y_out", 64'(bus.y_out), 64'd0);
    checkOutput("rst_coef_addr", 64'(bus.coef_addr), 64'd0);
    checkOutput("rst_rj_addr", 64'(bus.rj_addr), 64'd0);
    Reset = 1'b0;

    // Run 1: filled=1, every delay >= 1 so all terms vanish; k=5 from newest 2 wraps to 253.
    $display("[TB] run 1: delay gating, address wrap, overrun");
    for (int c = 0; c < NUM_CH; c++) begin
      fillChannel(c, 16'd1, 16'h0001, 16'h1234);
      coef_mem[c][0] = 16'h0005;
    end
    applyStimulus("r1", 8'd2, 97, 40'h0, 194, 40'h0, 40, 3, 8'd253, 1'b0);
    checkOutput("r1_overrun", 64'(bus.overrun), 64'd1);

    // Run 2: filled=2 (ignored start must not count); k=1 live, k=2 gated; ch1 subtracts k=0.
    $display("[TB] run 2: filled count, negation");
    clearMems();
    fillChannel(0, 16'd1, 16'h0002, 16'h0000);
    coef_mem[0][0] = 16'h0001;
    data_mem[0][99] = 16'h4000;
    data_mem[0][98] = 16'h4000;
    fillChannel(1, 16'd1, 16'h0100, 16'h0000);
    data_mem[1][100] = 16'h4000;
    applyStimulus("r2", 8'd100, 97, 40'h00_0000_4000, 194, 40'hFF_C000_4000, -1, 3, 8'd99, 1'b0);

    // Run 3: ch0 +x(newest) in every group; ch1 one rj=2 group of negative samples, rest rj=0.
    $display("[TB] run 3: positive sum, mixed rj, arithmetic shift");
    clearMems();
    fillChannel(0, 16'd1, 16'h0000, 16'h0000);
    data_mem[0][101] = 16'h4000;
    rj_mem[1][0] = 16'd2;
    coef_mem[1][0] = 16'h0000;
    coef_mem[1][1] = 16'h0001;
    data_mem[1][101] = 16'hFFFE;
    data_mem[1][100] = 16'hFFFF;
    applyStimulus("r3", 8'd101, 97, 40'h00_3FFF_C000, 152, 40'hFF_FFFF_FFFD, -1, 3, 8'd101, 1'b0);

    // Abort a run with Reset and confirm nothing completes afterwards.
    $display("[TB] reset mid-run");
    bus.newest_ptr = 8'd101;
    bus.start_compute = 1'b1;
    @(posedge Sclk);
    #1;
    bus.start_compute = 1'b0;
    repeat (20) @(posedge Sclk);
    #1;
    Reset = 1'b1;
    @(posedge Sclk);
    #1;
    checkOutput("mid_rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("mid_rst_y_out", 64'(bus.y_out), 64'd0);
    checkOutput("mid_rst_y_ch", 64'(bus.y_ch), 64'd0);
    checkOutput("mid_rst_overrun", 64'(bus.overrun), 64'd0);
    checkOutput("mid_rst_coef_addr", 64'(bus.coef_addr), 64'd0);
    checkOutput("mid_rst_ch_sel", 64'(bus.ch_sel), 64'd0);
    @(posedge Sclk);
    #1;
    Reset = 1'b0;
    stray = 0;
    for (int i = 0; i < 250; i++) begin
      @(posedge Sclk);
      #1;
      if (bus.y_valid || bus.done || bus.busy) stray++;
    end
    checkOutput("after_abort_quiet", 64'(stray), 64'd0);

    // Run 4: first start after reset, every rj=0: shifts only, no coefficient reads.
    $display("[TB] run 4: all rj zero");
    for (int c = 0; c < NUM_CH; c++) fillChannel(c, 16'd0, 16'h0101, 16'h7FFF);
    applyStimulus("r4", 8'd5, 49, 40'h0, 98, 40'h0, -1, -1, 8'd0, 1'b1);
    checkOutput("r4_overrun", 64'(bus.overrun), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end
endmodule

// File: doc/msdap_compute_engine.md
MSDAP_COMPUTE_ENGINE -- requirements
Module: msdap_compute_engine

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: channels processed sequentially per start.
REQ-002 The block SHALL have parameter NUM_RJ, default 16: number of rj groups per channel.
REQ-003 The block SHALL have parameter COEF_DEPTH, default 512: coefficient words per channel.
REQ-004 The block SHALL have parameter DATA_DEPTH, default 256, power of two: circular data buffer depth per channel.
REQ-005 The block SHALL have parameters DATA_W = 16, ACC_W = 40 and FRAC_W = 16, which set the sample width, the accumulator width and the number of zero LSBs appended to a sample.
REQ-006 Sclk  in  1  sole clock; all logic SHALL act on its rising edge.
REQ-007 Reset  in  1  synchronous, active-high reset.
REQ-008 start_compute  in  1  single-cycle pulse: a new sample is written for all channels.
REQ-009 newest_ptr  in  log2(DATA_DEPTH)  data address of the newest sample, sampled with start_compute.
REQ-010 rj_addr/rj_data  out/in  log2(NUM_RJ)/16  rj memory port.
REQ-011 coef_addr/coef_data  out/in  log2(COEF_DEPTH)/16  coefficient memory port; coef_data[8] is the sign (1 = subtract) and [7:0] is the delay k.
REQ-012 data_addr/data_data  out/in  log2(DATA_DEPTH)/DATA_W  data memory port.
REQ-013 ch_sel  out  log2(NUM_CH) (min 1)  channel whose memories are addressed.
REQ-014 y_out  out  ACC_W  result of the last finished channel.
REQ-015 y_valid  out  1  one-cycle pulse when y_out updates.
REQ-016 y_ch  out  log2(NUM_CH) (min 1)  channel of y_out.
REQ-017 busy  out  1  high in any state other than IDLE.
REQ-018 done  out  1  one-cycle pulse after the last channel completes.
REQ-019 overrun  out  1  sticky; cleared only by Reset.

Function
REQ-020 All memories SHALL be treated as synchronous-read: data is valid the cycle after the address is driven.
REQ-021 The block SHALL implement states IDLE, RJ_ADDR, RJ_LAT, C_ADDR, D_ADDR, ACC, SHIFT and OUT.
REQ-022 IDLE: on start_compute the block SHALL latch newest_ptr, set ch=0, j=0, coef_ptr=0, acc=0 and u=0, then go to RJ_ADDR.
REQ-023 RJ_ADDR SHALL drive rj_addr=j.
REQ-024 RJ_LAT SHALL load rcnt=rj_data, then go to C_ADDR if rcnt != 0, else to SHIFT.
REQ-025 C_ADDR SHALL drive coef_addr=coef_ptr.
REQ-026 D_ADDR SHALL latch sign and k, drive data_addr=(newest_ptr - k) mod DATA_DEPTH, and increment coef_ptr, wrapping modulo COEF_DEPTH.
REQ-027 ACC SHALL form x_ext as sign-extended data_data followed by FRAC_W zeros, in ACC_W bits.
REQ-028 ACC SHALL set u = u - x_ext if sign=1, else u = u + x_ext; the term is zero if k >= filled.
REQ-029 ACC SHALL decrement rcnt, then go to C_ADDR if rcnt != 0, else to SHIFT.
REQ-030 SHIFT SHALL set acc = (acc + u) >>> 1 (arithmetic shift), clear u and increment j.
REQ-031 From SHIFT the block SHALL go to OUT if j == NUM_RJ, else to RJ_ADDR.
REQ-032 OUT SHALL register y_out=acc and y_ch=ch, and pulse y_valid.
REQ-033 If ch < NUM_CH-1, OUT SHALL increment ch and clear j, coef_ptr, acc and u, then go to RJ_ADDR.
REQ-034 Otherwise OUT SHALL pulse done in the following cycle and go to IDLE.
REQ-035 filled SHALL be an internal count of accepted starts, saturating at DATA_DEPTH and incremented on each accepted start_compute.
REQ-036 Cycles per channel SHALL equal sum over j of (3 + 3*rj_j) + 1.
REQ-037 All arithmetic SHALL wrap modulo 2^ACC_W with no saturation.
REQ-038 start_compute while busy SHALL be ignored, set overrun, and leave filled unchanged.
REQ-039 A start_compute in the same cycle as the done pulse SHALL be accepted, since the FSM is already in IDLE.
REQ-040 rj=0 SHALL produce no coefficient or data reads; the group still applies one shift.
REQ-041 k=0 SHALL address newest_ptr.
REQ-042 The subtraction newest_ptr - k SHALL wrap modulo DATA_DEPTH.
REQ-043 ch_sel SHALL equal ch throughout the computation.

Reset
REQ-044 While Reset is high, the state SHALL be IDLE.
REQ-045 Reset SHALL clear y_out, y_ch, filled, overrun and all counters and addresses.
REQ-046 Reset SHALL hold y_valid, done and busy low.
REQ-047 Reset asserted mid-computation SHALL abort it with no y_valid or done pulse.
REQ-048 The first start_compute after Reset release SHALL be accepted.

Verification
REQ-049 NUM_CH=1, all rj=1, each coef=+k0, x(newest)=0x4000: start -> y_valid 97 cycles after the start edge; y_out = 0x4000_0000 * (1 - 2^-16), bit-exact per REQ-030.
REQ-050 Coef sign=1 in all groups: y_out is the exact negation of the sign=0 result.
REQ-051 filled=1, coefficient k=5: term is zero; y_out=0 when all other coefficients reference k >= 1.
REQ-052 newest_ptr=2, k=5: data_addr = 253 (DATA_DEPTH=256).
REQ-053 NUM_CH=2, second start_compute issued mid-run: ignored, overrun=1, and exactly two y_valid pulses with y_ch=0 then 1, followed by done.
REQ-054 All rj=0: y_out=0 after 16*3+1 = 49 cycles, and no coef_addr changes occur.
